// File: rtl/aes_stream_cipher.sv
// AES-128 streaming encryptor with a beat-serial input and output interface.
// Key, IV and plaintext blocks share one input stream. Rounds run iteratively.
module aes_round (
  input  logic [127:0] st_i,
  input  logic [127:0] key_i,
  input  logic [3:0]   rc_i,
  output logic [127:0] st_o,
  output logic [127:0] key_o
);
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  logic [7:0] nk [16];
  logic [7:0] tw [4];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse is a^254 in GF(2^8); zero maps to zero.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] b;
    sq = a;
    b  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      b  = gmul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = sbox(st_i[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1]
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2])
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2])
                ^ xt(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end
    tw[0] = sbox(key_i[111:104]) ^ rcon(rc_i);
    tw[1] = sbox(key_i[119:112]);
    tw[2] = sbox(key_i[127:120]);
    tw[3] = sbox(key_i[103:96]);
    for (int i = 0; i < 4; i++) nk[i] = key_i[8*i +: 8] ^ tw[i];
    for (int i = 4; i < 16; i++) nk[i] = key_i[8*i +: 8] ^ nk[i-4];
    for (int i = 0; i < 16; i++) begin
      key_o[8*i +: 8] = nk[i];
      st_o[8*i +: 8]  = ((rc_i == 4'd10) ? sr[i] : mc[i]) ^ nk[i];
    end
  end
endmodule

module aes_stream_cipher #(
  parameter int DW     = 8,
  parameter int CBC_EN = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic [1:0]    s_type,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          key_loaded,
  output logic          busy,
  output logic          err
);
  localparam int NB = 128 / DW;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [1:0] T_PT  = 2'b00;
  localparam logic [1:0] T_KEY = 2'b01;
  localparam logic [1:0] T_IV  = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  beat_q, beat_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [1:0]     type_q, type_d;
  logic [127:0]   buf_q, buf_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   chain_q, chain_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   wk_q, wk_d;
  logic [127:0]   out_q, out_d;
  logic           kl_q, kl_d;
  logic           err_q, err_d;

  logic [127+DW:0] cat;
  logic [127:0]    buf_nx;
  logic [127:0]    rnd_st;
  logic [127:0]    rnd_key;
  logic [1:0]      blk_type;
  logic            last;

  aes_round u_round (
    .st_i  (st_q),
    .key_i (wk_q),
    .rc_i  (rnd_q),
    .st_o  (rnd_st),
    .key_o (rnd_key)
  );

  assign cat        = {s_data, buf_q};
  assign buf_nx     = cat[127+DW:DW];
  assign blk_type   = (state_q == IDLE) ? s_type : type_q;
  assign last       = (beat_q == CW'(NB-1));
  assign s_ready    = (state_q == IDLE) || (state_q == LOAD);
  assign m_valid    = (state_q == OUT);
  assign busy       = (state_q == RUN) || (state_q == OUT);
  assign m_data     = out_q[DW-1:0];
  assign key_loaded = kl_q;
  assign err        = err_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rnd_d   = rnd_q;
    type_d  = type_q;
    buf_d   = buf_q;
    key_d   = key_q;
    chain_d = chain_q;
    st_d    = st_q;
    wk_d    = wk_q;
    out_d   = out_q;
    kl_d    = kl_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE, LOAD: begin
        if (s_valid) begin
          buf_d  = buf_nx;
          type_d = blk_type;
          if (last) begin
            beat_d  = '0;
            state_d = IDLE;
            unique case (blk_type)
              T_KEY: begin
                key_d = buf_nx;
                kl_d  = 1'b1;
              end
              T_IV: begin
                if (CBC_EN != 0) chain_d = buf_nx;
                else err_d = 1'b1;
              end
              T_PT: begin
                if (kl_q) begin
                  state_d = RUN;
                  rnd_d   = 4'd0;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end else begin
            beat_d  = beat_q + CW'(1);
            state_d = LOAD;
          end
        end
      end
      RUN: begin
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'd0) begin
          st_d = buf_q ^ key_q ^ ((CBC_EN != 0) ? chain_q : 128'h0);
          wk_d = key_q;
        end else if (rnd_q == 4'd10) begin
          out_d   = rnd_st;
          rnd_d   = 4'd0;
          state_d = OUT;
          if (CBC_EN != 0) chain_d = rnd_st;
        end else begin
          st_d = rnd_st;
          wk_d = rnd_key;
        end
      end
      OUT: begin
        if (m_ready) begin
          out_d = out_q >> DW;
          if (last) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rnd_q   <= '0;
      type_q  <= '0;
      buf_q   <= '0;
      key_q   <= '0;
      chain_q <= '0;
      st_q    <= '0;
      wk_q    <= '0;
      out_q   <= '0;
      kl_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rnd_q   <= rnd_d;
      type_q  <= type_d;
      buf_q   <= buf_d;
      key_q   <= key_d;
      chain_q <= chain_d;
      st_q    <= st_d;
      wk_q    <= wk_d;
      out_q   <= out_d;
      kl_q    <= kl_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_aes_stream_cipher.sv
// Bench for aes_stream_cipher: three instances (DW=8 ECB, DW=128 ECB,
// DW=32 CBC) driven in turn against a scoreboard of expected beats.
module tb_aes_stream_cipher;
  logic clk = 1'b0;
  logic rst;
  logic sv [3];
  logic mr [3];
  logic [1:0] st [3];
  logic sr [3];
  logic mv [3];
  logic kl [3];
  logic bz [3];
  logic er [3];
  logic [7:0]   sd0;
  logic [127:0] sd1;
  logic [31:0]  sd2;
  logic [7:0]   md0;
  logic [127:0] md1;
  logic [31:0]  md2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e_last = 0;
  logic [127:0] sbq [$];
  logic [7:0] sbt [256];
  logic [127:0] key, pt, ct, ct2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_stream_cipher #(.DW(8), .CBC_EN(0)) u_d0 (
    .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(sr[0]),
    .s_data(sd0), .s_type(st[0]), .m_valid(mv[0]), .m_ready(mr[0]),
    .m_data(md0), .key_loaded(kl[0]), .busy(bz[0]), .err(er[0]));

  aes_stream_cipher #(.DW(128), .CBC_EN(0)) u_d1 (
    .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(sr[1]),
    .s_data(sd1), .s_type(st[1]), .m_valid(mv[1]), .m_ready(mr[1]),
    .m_data(md1), .key_loaded(kl[1]), .busy(bz[1]), .err(er[1]));

  aes_stream_cipher #(.DW(32), .CBC_EN(1)) u_d2 (
    .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(sr[2]),
    .s_data(sd2), .s_type(st[2]), .m_valid(mv[2]), .m_ready(mr[2]),
    .m_data(md2), .key_loaded(kl[2]), .busy(bz[2]), .err(er[2]));

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] fb(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] p, input logic [127:0] k);
    logic [7:0] w [44][4];
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] tmp [4];
    logic [7:0] rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 4; r++) w[i][r] = k[8*(4*i+r) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int r = 0; r < 4; r++) tmp[r] = w[i-1][r];
      if (i % 4 == 0) begin
        tmp[0] = sbt[w[i-1][1]] ^ rc;
        tmp[1] = sbt[w[i-1][2]];
        tmp[2] = sbt[w[i-1][3]];
        tmp[3] = sbt[w[i-1][0]];
        rc = m_mul(rc, 8'h02);
      end
      for (int r = 0; r < 4; r++) w[i][r] = w[i-4][r] ^ tmp[r];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = p[8*(4*c+r) +: 8] ^ w[c][r];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sbt[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          s[0][c] = m_mul(t[0][c], 8'h02) ^ m_mul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ m_mul(t[1][c], 8'h02) ^ m_mul(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ m_mul(t[2][c], 8'h02) ^ m_mul(t[3][c], 8'h03);
          s[3][c] = m_mul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ m_mul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rd+c][r];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[8*(4*c+r) +: 8] = s[r][c];
    return res;
  endfunction

  function automatic int dw_of(input int d);
    case (d)
      0: return 8;
      1: return 128;
      default: return 32;
    endcase
  endfunction

  function automatic logic [127:0] get_md(input int d);
    case (d)
      0: return 128'(md0);
      1: return md1;
      default: return 128'(md2);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int d, input logic [127:0] v);
    case (d)
      0: sd0 = v[7:0];
      1: sd1 = v;
      default: sd2 = v[31:0];
    endcase
  endtask

  // Later beats carry a different s_type to show it is ignored.
  task automatic send(input int d, input logic [1:0] t, input logic [127:0] blk,
                      input int nbeats = -1);
    int w, n, tmo;
    w = dw_of(d);
    n = (nbeats < 0) ? 128 / w : nbeats;
    for (int b = 0; b < n; b++) begin
      set_data(d, blk >> (w * b));
      st[d] = (b == 0) ? t : (t ^ 2'b11);
      sv[d] = 1'b1;
      tmo = 0;
      while (!sr[d] && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      chk("s_ready", 128'(sr[d]), 128'(1));
      @(posedge clk);
      @(negedge clk);
    end
    sv[d] = 1'b0;
    e_last = cyc;
  endtask

  task automatic push_ct(input int d, input logic [127:0] c);
    int w;
    logic [127:0] mask;
    w = dw_of(d);
    mask = (128'(1) << w) - 128'(1);
    for (int b = 0; b < 128 / w; b++) sbq.push_back((c >> (w * b)) & mask);
  endtask

  task automatic collect(input int d, input int stall_beat = -1);
    int w, tmo;
    logic [127:0] exp;
    w = dw_of(d);
    tmo = 0;
    while (!mv[d] && tmo < 40) begin
      @(negedge clk);
      tmo++;
    end
    chk("m_valid_rise", 128'(mv[d]), 128'(1));
    chk("latency", 128'(cyc - e_last), 128'(11));
    for (int b = 0; b < 128 / w; b++) begin
      chk("m_valid_hold", 128'(mv[d]), 128'(1));
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL scoreboard observed=empty expected=entry");
        exp = '0;
      end else begin
        exp = sbq.pop_front();
      end
      chk("m_data", get_md(d), exp);
      if (b == stall_beat) begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_data", get_md(d), exp);
          chk("stall_valid", 128'(mv[d]), 128'(1));
        end
      end
      mr[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mr[d] = 1'b0;
    end
    chk("m_valid_fall", 128'(mv[d]), 128'(0));
    chk("busy_fall", 128'(bz[d]), 128'(0));
  endtask

  task automatic err_pulse(input int d, input string tag);
    chk({tag, "_err_hi"}, 128'(er[d]), 128'(1));
    @(negedge clk);
    chk({tag, "_err_lo"}, 128'(er[d]), 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reset_state(input int d);
    chk("rst_s_ready", 128'(sr[d]), 128'(1));
    chk("rst_m_valid", 128'(mv[d]), 128'(0));
    chk("rst_key_loaded", 128'(kl[d]), 128'(0));
    chk("rst_busy", 128'(bz[d]), 128'(0));
    chk("rst_err", 128'(er[d]), 128'(0));
    chk("rst_m_data", get_md(d), 128'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] inv, cst, bb;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (m_mul(8'(a), 8'(j)) == 8'h01) inv = 8'(j);
      cst = 8'h63;
      for (int i = 0; i < 8; i++)
        bb[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
              ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbt[a] = bb;
    end
    key = fb(128'h000102030405060708090a0b0c0d0e0f);
    pt  = fb(128'h00112233445566778899aabbccddeeff);
    ct  = fb(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    for (int d = 0; d < 3; d++) begin
      sv[d] = 1'b0; mr[d] = 1'b0; st[d] = 2'b00;
    end
    sd0 = '0; sd1 = '0; sd2 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) reset_state(d);

    send(0, 2'b00, pt);
    err_pulse(0, "pt_nokey");
    chk("nokey_kl", 128'(kl[0]), 128'(0));
    repeat (15) @(negedge clk);
    chk("nokey_no_mvalid", 128'(mv[0]), 128'(0));

    send(0, 2'b10, 128'h0);
    err_pulse(0, "iv_ecb");

    send(0, 2'b01, key);
    chk("key_loaded", 128'(kl[0]), 128'(1));
    chk("key_no_err", 128'(er[0]), 128'(0));

    send(0, 2'b11, pt);
    err_pulse(0, "type11");
    chk("type11_kl", 128'(kl[0]), 128'(1));

    push_ct(0, ct);
    send(0, 2'b00, pt);
    chk("busy_run", 128'(bz[0]), 128'(1));
    chk("ready_run", 128'(sr[0]), 128'(0));
    collect(0, 5);

    push_ct(0, ct);
    send(0, 2'b00, pt);
    sv[0] = 1'b1; sd0 = 8'ha5; st[0] = 2'b01;
    repeat (5) begin
      @(negedge clk);
      chk("no_accept_busy", 128'(sr[0]), 128'(0));
    end
    sv[0] = 1'b0;
    collect(0);

    send(1, 2'b01, key);
    push_ct(1, ct);
    send(1, 2'b00, pt);
    collect(1);
    push_ct(1, ct);
    send(1, 2'b00, pt);
    collect(1);

    send(2, 2'b10, 128'h0);
    chk("iv_cbc_no_err", 128'(er[2]), 128'(0));
    send(2, 2'b01, key);
    push_ct(2, ct);
    send(2, 2'b00, pt);
    collect(2);
    ct2 = aes_model(pt ^ ct, key);
    push_ct(2, ct2);
    send(2, 2'b00, pt);
    collect(2);

    send(0, 2'b01, key, 5);
    do_reset();
    reset_state(0);
    send(0, 2'b01, key);
    send(0, 2'b00, pt);
    repeat (3) @(negedge clk);
    chk("midrun_busy", 128'(bz[0]), 128'(1));
    do_reset();
    reset_state(0);
    repeat (15) @(negedge clk);
    chk("midrun_no_mvalid", 128'(mv[0]), 128'(0));
    send(0, 2'b01, key);
    push_ct(0, ct);
    send(0, 2'b00, pt);
    collect(0);

    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_stream_cipher.md
AES_STREAM_CIPHER -- requirements
Module: aes_stream_cipher

Interface
REQ-001 SHALL have parameter DW, default 8, meaning bits per input/output beat; legal values 8, 16, 32, 64, 128; NB = 128/DW beats per block.
REQ-002 SHALL have parameter CBC_EN, default 0, meaning 1 enables CBC chaining and IV load, 0 gives ECB.
REQ-003 SHALL have ports as follows; one clock; reset is synchronous and active-high:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid & s_ready.
- s_data  in  DW  input beat.
- s_type  in  2  block type: 00 plaintext, 01 key, 10 IV, 11 reserved.
- m_valid  out  1  ciphertext beat valid.
- m_ready  in  1  ciphertext beat taken when m_valid & m_ready.
- m_data  out  DW  ciphertext beat.
- key_loaded  out  1  a full key has been stored since reset.
- busy  out  1  high in RUN and OUT.
- err  out  1  one-cycle pulse on a discarded block.

Function
REQ-004 SHALL implement FSM IDLE, LOAD, RUN, OUT.
REQ-005 IDLE/LOAD: s_ready=1; RUN/OUT: s_ready=0.
REQ-006 Block type SHALL be latched from s_type on the first accepted beat of a block; s_type on later beats of the same block is ignored.
REQ-007 Beats SHALL assemble into a 128-bit buffer by right shift, new beat entering [127:128-DW]; first beat ends in [DW-1:0], i.e. FIPS-197 byte 0 in bits [7:0].
REQ-008 Beat counter SHALL count 0..NB-1 and wrap to 0 on the NB-th beat; IDLE->LOAD on first beat; block completes on NB-th beat (for DW=128, first beat completes it, IDLE straight to completion).
REQ-009 Completed key block SHALL be stored in a persistent key register and set key_loaded=1; FSM returns to IDLE.
REQ-010 Completed IV block with CBC_EN=1 SHALL load the chain register and return to IDLE; with CBC_EN=0 it SHALL be discarded with err pulse.
REQ-011 Completed type-11 block SHALL be discarded with err pulse.
REQ-012 Completed plaintext block with key_loaded=0 SHALL be discarded with err pulse, FSM to IDLE.
REQ-013 Completed plaintext block with key_loaded=1 SHALL enter RUN with round counter 0.
REQ-014 RUN round 0: state = buffer ^ key ^ (CBC_EN ? chain : 0), working key = stored key.
REQ-015 RUN rounds 1..9: state and working key updated from the existing rounds module (rc = round count); round 10: final round result loaded into output register, FSM to OUT.
REQ-016 Stored key SHALL not be modified by encryption; consecutive plaintext blocks reuse it.
REQ-017 Latency: last input handshake on edge E -> m_valid high after edge E+11.
REQ-018 OUT: m_data = output register [DW-1:0]; each m handshake shifts output register right by DW; m_valid holds with m_data stable while m_ready=0.
REQ-019 After the NB-th output handshake, FSM SHALL go to IDLE; with CBC_EN=1, chain SHALL equal the ciphertext just sent.
REQ-020 s_valid with no acceptance SHALL not change the buffer or counters.

Reset
REQ-021 rst=1 at a clock edge SHALL from any state set FSM IDLE, beat and round counters 0, key_loaded 0, chain 0, m_valid 0, err 0, busy 0, and discard any partial or in-flight block.
REQ-022 After reset, s_ready=1, m_data=0, and a new key load is required before encryption.

Verification
REQ-023 DW=8, ECB: key 000102..0f, plaintext 00112233445566778899aabbccddeeff, each sent byte 0 first -> 16 m_data bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; m_valid rises 11 edges after the last plaintext handshake.
REQ-024 DW=32 and DW=128, same vectors -> same 128-bit ciphertext in the same byte order; second plaintext block without key reload -> identical ciphertext.
REQ-025 Plaintext block sent after reset with no key -> err pulse, no m_valid; type-11 block -> err pulse, key_loaded unchanged.
REQ-026 CBC_EN=1, IV=0, same plaintext twice -> first ciphertext as in REQ-023; second ciphertext = AES(plaintext ^ first ciphertext) per software model.
REQ-027 m_ready held low 5 cycles mid-output -> m_data stable, no beat lost or duplicated; rst mid-LOAD and mid-RUN -> idle state per REQ-021, and the next full key+plaintext sequence gives the correct ciphertext.
